// File: rtl/sync_gearbox_fifo_pkg.sv
// Shared sizing helpers and configuration checks for the gearbox FIFO.
package sync_gearbox_fifo_pkg;

  function automatic int unsigned gb_ratio(input int unsigned in_w, input int unsigned out_w);
    return (out_w == 0) ? 0 : in_w / out_w;
  endfunction

  function automatic bit gb_is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Address width that never collapses to zero bits.
  function automatic int unsigned gb_addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned gb_rptr_w(input int unsigned depth, input int unsigned ratio);
    return gb_addr_w(depth * ratio);
  endfunction

  function automatic int unsigned gb_cnt_w(input int unsigned depth, input int unsigned ratio);
    return gb_rptr_w(depth, ratio) + 1;
  endfunction

  function automatic int unsigned gb_sel_shift(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 0;
  endfunction

  function automatic bit gb_cfg_ok(input int unsigned in_w, input int unsigned out_w,
                                   input int unsigned depth);
    return (out_w != 0) && ((in_w % out_w) == 0) && gb_is_pow2(gb_ratio(in_w, out_w))
           && gb_is_pow2(depth) && (depth >= 2);
  endfunction

endpackage

// File: rtl/sync_gearbox_fifo_mem.sv
// DEPTH x IN_WIDTH storage with one write port and a registered slice-select read port.
module sync_gearbox_fifo_mem #(
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned RATIO     = 2,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned SEL_W     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [RATIO*OUT_WIDTH-1:0]   i_wr_data,
  input  logic                         i_rd_en,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  input  logic [SEL_W-1:0]             i_rd_sel,
  output logic [OUT_WIDTH-1:0]         o_rd_data
);

  // Slice 0 occupies the low bits of each stored word.
  logic [RATIO-1:0][OUT_WIDTH-1:0] r_mem [DEPTH];
  logic [OUT_WIDTH-1:0]            r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr][i_rd_sel];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_gearbox_fifo.sv
// Single-clock wide-in / narrow-out FIFO with registered status flags.
// Define SYNC_GEARBOX_FIFO_ERR_STICKY_EN to make err_checker hold until reset.
module sync_gearbox_fifo
  import sync_gearbox_fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH        = 32,
  parameter int unsigned OUT_WIDTH       = 16,
  parameter int unsigned DEPTH           = 32,
  parameter int unsigned FULL_THRESHOLD  = 8,
  parameter int unsigned EMPTY_THRESHOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 rd_en,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 err_checker
);

  localparam int unsigned R      = gb_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned ADDR_W = gb_addr_w(DEPTH);
  localparam int unsigned RPTR_W = gb_rptr_w(DEPTH, R);
  localparam int unsigned CNT_W  = gb_cnt_w(DEPTH, R);
  localparam int unsigned SEL_W  = gb_addr_w(R);
  localparam int unsigned SEL_SH = gb_sel_shift(R);
  localparam int unsigned CAP    = DEPTH * R;
  localparam logic        AF_RST = 1'(DEPTH <= FULL_THRESHOLD);

  if (!gb_cfg_ok(IN_WIDTH, OUT_WIDTH, DEPTH)) begin : g_cfg_check
    $error("sync_gearbox_fifo: IN_WIDTH/OUT_WIDTH must be a power-of-two ratio and DEPTH a power of two >= 2");
  end

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [RPTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W-1:0]  w_free_nxt;
  logic              r_full, r_empty, r_afull, r_aempty, r_err;
  logic              w_wr_acc, w_rd_acc, w_err_evt;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [SEL_W-1:0]  w_rd_sel;

  assign w_wr_acc  = wr_en & ~r_full;
  assign w_rd_acc  = rd_en & ~r_empty;
  assign w_err_evt = (wr_en & r_full) | (rd_en & r_empty);
  assign w_rd_addr = ADDR_W'(r_rd_ptr >> SEL_SH);
  assign w_rd_sel  = SEL_W'(r_rd_ptr & RPTR_W'(R - 1));

  // Occupancy in OUT slots after this edge; flags are registered from it.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc) w_count_nxt = w_count_nxt + CNT_W'(R);
    if (w_rd_acc) w_count_nxt = w_count_nxt - CNT_W'(1);
    w_free_nxt = CNT_W'(CAP) - w_count_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= AF_RST;
      r_aempty <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + RPTR_W'(1);
      r_count  <= w_count_nxt;
      r_full   <= (w_free_nxt < CNT_W'(R));
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (32'(w_free_nxt >> SEL_SH) <= FULL_THRESHOLD);
      r_aempty <= (32'(w_count_nxt) <= EMPTY_THRESHOLD);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
`ifdef SYNC_GEARBOX_FIFO_ERR_STICKY_EN
      r_err <= r_err | w_err_evt;
`else
      r_err <= w_err_evt;
`endif
    end
  end

  sync_gearbox_fifo_mem #(
    .OUT_WIDTH (OUT_WIDTH),
    .RATIO     (R),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .SEL_W     (SEL_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (din),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (w_rd_addr),
    .i_rd_sel  (w_rd_sel),
    .o_rd_data (dout)
  );

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign err_checker  = r_err;

endmodule

// File: tb/tb_sync_gearbox_fifo.sv
// Randomized bench for sync_gearbox_fifo against a slice-queue reference model.
`timescale 1ns/1ps
module tb_sync_gearbox_fifo;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int DEPTH = 32;
  localparam int FT    = 8;
  localparam int ET    = 8;
  localparam int R     = IN_W / OUT_W;
  localparam int CAP   = DEPTH * R;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [IN_W-1:0]   din = '0;
  logic [OUT_W-1:0]  dout;
  logic              full, empty, almost_full, almost_empty, err_checker;

  always #5 clk = ~clk;

  sync_gearbox_fifo #(
    .IN_WIDTH        (IN_W),
    .OUT_WIDTH       (OUT_W),
    .DEPTH           (DEPTH),
    .FULL_THRESHOLD  (FT),
    .EMPTY_THRESHOLD (ET)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .err_checker  (err_checker)
  );

  // Reference model: the FIFO is just a queue of OUT slices, oldest first.
  logic [OUT_W-1:0] m_q[$];
  logic [OUT_W-1:0] m_dout;
  logic             m_err;
  int               n_checks = 0;
  int               n_pass   = 0;
  string            g_phase  = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic check_state();
    int occ;
    occ = m_q.size();
    check({g_phase, ".dout"},         32'(dout),         32'(m_dout));
    check({g_phase, ".empty"},        32'(empty),        32'(occ == 0));
    check({g_phase, ".full"},         32'(full),         32'((CAP - occ) < R));
    check({g_phase, ".almost_full"},  32'(almost_full),  32'(((CAP - occ) / R) <= FT));
    check({g_phase, ".almost_empty"}, 32'(almost_empty), 32'(occ <= ET));
    check({g_phase, ".err_checker"},  32'(err_checker),  32'(m_err));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = '0;
    m_err  = 1'b0;
  endtask

  task automatic cycle(input logic w, input logic r, input logic [IN_W-1:0] d);
    logic wa, ra, evt;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    if (rst) begin
      wa  = w && ((CAP - m_q.size()) >= R);
      ra  = r && (m_q.size() != 0);
      evt = (w && !wa) || (r && !ra);
      if (ra) m_dout = m_q.pop_front();
      if (wa) begin
        for (int s = 0; s < R; s++) m_q.push_back(d[s*OUT_W +: OUT_W]);
      end
`ifdef SYNC_GEARBOX_FIFO_ERR_STICKY_EN
      m_err = m_err | evt;
`else
      m_err = evt;
`endif
    end else begin
      model_reset();
    end
    #1;
    check_state();
  endtask

  task automatic rand_phase(input string name, input int n, input int p_wr, input int p_rd);
    g_phase = name;
    for (int i = 0; i < n; i++)
      cycle(1'($urandom_range(0, 99) < p_wr), 1'($urandom_range(0, 99) < p_rd), $urandom);
  endtask

  initial begin
    model_reset();
    g_phase = "reset";
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    rst = 1'b1;

    g_phase = "fill";
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, $urandom);
      if (i == 23) check("fill.af_after_24", 32'(almost_full), 32'd1);
    end
    check("fill.full_after_32", 32'(full), 32'd1);

    g_phase = "overflow";
    cycle(1'b1, 1'b0, $urandom);
    cycle(1'b1, 1'b0, $urandom);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, $urandom);

    g_phase = "drain";
    for (int i = 0; i < CAP + 4; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    g_phase = "thresh";
    for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0, $urandom);
    check("thresh.af_at_8_free", 32'(almost_full), 32'd1);
    for (int i = 0; i < 48; i++) cycle(1'b0, 1'b1, '0);
    check("thresh.empty_at_0", 32'(empty), 32'd1);

    g_phase = "simul";
    cycle(1'b1, 1'b0, $urandom);
    cycle(1'b1, 1'b0, $urandom);
    cycle(1'b1, 1'b1, $urandom);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0);

    rand_phase("rnd_fill", 250, 75, 30);
    rand_phase("rnd_drain", 250, 25, 75);
    rand_phase("rnd_mix", 250, 50, 50);
    rand_phase("rnd_prefill", 60, 90, 10);

    // Asynchronous reset between clock edges must clear flags without a clock.
    g_phase = "async_rst";
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_state();
    cycle(1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;

    rand_phase("post_rst", 200, 55, 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
